// File: rtl/sigmoid_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sigmoid_arbiter_if
// Brief    : Requester-side bundle of the shared sigmoid engine arbiter:
//            request levels, operand vectors, grant and tagged response.
// Revision : 1.0 - initial release
// ============================================================================
interface sigmoid_arbiter_if #(
    parameter int S  = 32,
    parameter int N  = 2,
    parameter int R  = 4,
    parameter int IW = $clog2(R)
);
    logic [R-1:0]     req;
    logic [R*S*N-1:0] x_in;
    logic [R-1:0]     gnt;
    logic             rsp_valid;
    logic             rsp_err;
    logic [IW-1:0]    rsp_id;
    logic [S*N-1:0]   rsp_y;
    logic             busy;

    // Requesters drive req/x_in and observe grant and response.
    modport master (
        output req, x_in,
        input  gnt, rsp_valid, rsp_err, rsp_id, rsp_y, busy
    );

    // The arbiter consumes requests and produces grant and response.
    modport slave (
        input  req, x_in,
        output gnt, rsp_valid, rsp_err, rsp_id, rsp_y, busy
    );
endinterface
`default_nettype wire

// File: rtl/sigmoid_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sigmoid_arbiter
// Brief    : Round-robin sharing of one N-lane sigmoid engine among R
//            requesters, with operand latching, engine start/clear sequencing,
//            id-tagged responses and a watchdog abort.
// Revision : 1.0 - initial release
// ============================================================================
module sigmoid_arbiter #(
    parameter int S       = 32,
    parameter int N       = 2,
    parameter int R       = 4,
    parameter int TIMEOUT = 64,
    parameter int IW      = $clog2(R)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    sigmoid_arbiter_if.slave    bus,
    output logic                eng_rst_n,
    output logic                eng_start,
    output logic [S*N-1:0]      eng_x,
    input  wire logic [S*N-1:0] eng_y,
    input  wire logic           eng_done
);
    localparam int W  = S * N;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] rsp_id_q, rsp_id_d;
    logic [R-1:0]  gnt_q, gnt_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  rsp_y_q, rsp_y_d;
    logic          rsp_err_q, rsp_err_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          pick_found;
    logic [IW-1:0] pick_id;
    logic [IW-1:0] cand;
    logic [W-1:0]  x_pick;

    // Cyclic search for the first active request at or after the pointer.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = 0; k < R; k++) begin
            cand = IW'((int'(ptr_q) + k) % R);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Select the winner's operand slice for latching.
    always_comb begin
        x_pick = '0;
        for (int r = 0; r < R; r++) begin
            if (pick_id == IW'(r)) begin
                x_pick = bus.x_in[r*W +: W];
            end
        end
    end

    // Next-state and register updates for the grant/launch/wait/respond cycle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        rsp_id_d  = rsp_id_q;
        gnt_d     = gnt_q;
        x_d       = x_q;
        rsp_y_d   = rsp_y_q;
        rsp_err_d = rsp_err_q;
        cnt_d     = cnt_q;
        done_d    = eng_done;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d   = {{(R-1){1'b0}}, 1'b1} << pick_id;
                    x_d     = x_pick;
                    id_d    = pick_id;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // Pretend done was already high so a level left over from the
                // previous operation cannot look like a fresh completion.
                cnt_d   = '0;
                done_d  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done && !done_q) begin
                    rsp_y_d   = eng_y;
                    rsp_err_d = 1'b0;
                    rsp_id_d  = id_q;
                    state_d   = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_y_d   = '0;
                    rsp_err_d = 1'b1;
                    rsp_id_d  = id_q;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                ptr_d   = (int'(id_q) == R - 1) ? '0 : id_q + 1'b1;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            rsp_id_q  <= '0;
            gnt_q     <= '0;
            x_q       <= '0;
            rsp_y_q   <= '0;
            rsp_err_q <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            rsp_id_q  <= rsp_id_d;
            gnt_q     <= gnt_d;
            x_q       <= x_d;
            rsp_y_q   <= rsp_y_d;
            rsp_err_q <= rsp_err_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

    // Outputs are forced to their reset values for as long as rst is high.
    assign bus.gnt       = rst ? '0 : gnt_q;
    assign bus.rsp_valid = !rst && (state_q == ST_RESP);
    assign bus.rsp_err   = rst ? 1'b0 : rsp_err_q;
    assign bus.rsp_id    = rst ? '0 : rsp_id_q;
    assign bus.rsp_y     = rst ? '0 : rsp_y_q;
    assign bus.busy      = !rst && (state_q != ST_IDLE);
    assign eng_rst_n     = !rst && (state_q != ST_LAUNCH);
    assign eng_start     = !rst && (state_q == ST_LAUNCH);
    assign eng_x         = rst ? '0 : x_q;
endmodule
`default_nettype wire

// File: tb/tb_sigmoid_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigmoid_arbiter
// Brief    : Directed bench for sigmoid_arbiter with a transaction-timeline
//            reference model and hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigmoid_arbiter;
    localparam int S  = 32;
    localparam int N  = 2;
    localparam int R  = 4;
    localparam int TO = 16;
    localparam int IW = 2;
    localparam int W  = S * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic eng_rst_n, eng_start;
    logic [W-1:0] eng_x;
    logic [W-1:0] eng_y = '0;
    logic eng_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int got[$];

    // engine model controls
    int eng_lat    = -1;
    bit eng_manual = 1'b0;
    bit man_done   = 1'b0;
    int kn         = 0;

    sigmoid_arbiter_if #(.S(S), .N(N), .R(R), .IW(IW)) bus ();

    sigmoid_arbiter #(.S(S), .N(N), .R(R), .TIMEOUT(TO), .IW(IW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .eng_rst_n(eng_rst_n), .eng_start(eng_start), .eng_x(eng_x),
        .eng_y(eng_y), .eng_done(eng_done)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic expire(input string nm, input int budget);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no event within %0d cycles", nm, budget);
    endtask

    // Engine: done level rises eng_lat cycles after the launch cycle and stays
    // high until the next launch; manual mode copies man_done instead.
    initial begin
        eng_done = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) kn = 1;
            else if (kn > 0) kn++;
            @(posedge clk);
            #2;
            eng_done = eng_manual ? man_done : (eng_lat > 0 && kn >= eng_lat);
        end
    end

    // Reference model: per operation, a launch cycle and a response cycle
    // derived from the arbitration, done-rise and timeout rules.
    initial begin
        bit m_act = 0, m_prev = 0, in_op, e_start, m_pend_err = 0, m_last_err = 0;
        int m_id = 0, m_launch = 0, m_resp = -1, m_ptr = 0, m_last_id = 0;
        logic [W-1:0] m_x = '0, m_pend_y = '0, m_last_y = '0;
        logic [R-1:0] e_gnt;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_gnt", bus.gnt, '0);
                chk("rst_busy", bus.busy, '0);
                chk("rst_valid", bus.rsp_valid, '0);
                chk("rst_err", bus.rsp_err, '0);
                chk("rst_id", bus.rsp_id, '0);
                chk("rst_y", bus.rsp_y, '0);
                chk("rst_start", eng_start, '0);
                chk("rst_engrstn", eng_rst_n, '0);
                chk("rst_engx", eng_x, '0);
                m_act = 0; m_ptr = 0; m_last_y = '0; m_last_err = 0; m_last_id = 0;
            end else begin
                in_op   = m_act && (cyc >= m_launch);
                e_start = m_act && (cyc == m_launch);
                if (m_act && cyc == m_resp) begin
                    m_last_y = m_pend_y; m_last_err = m_pend_err; m_last_id = m_id;
                end
                e_gnt = in_op ? (4'b0001 << m_id) : 4'b0000;
                chk("gnt", bus.gnt, e_gnt);
                chk("busy", bus.busy, in_op);
                chk("eng_start", eng_start, e_start);
                chk("eng_rst_n", eng_rst_n, !e_start);
                chk("rsp_valid", bus.rsp_valid, m_act && (cyc == m_resp));
                chk("rsp_id", bus.rsp_id, m_last_id);
                chk("rsp_err", bus.rsp_err, m_last_err);
                chk("rsp_y", bus.rsp_y, m_last_y);
                if (in_op) chk("eng_x", eng_x, m_x);
                if (m_act) begin
                    if (cyc == m_launch) begin
                        m_prev = 1;
                    end else if (m_resp < 0) begin
                        if (eng_done && !m_prev) begin
                            m_resp = cyc + 1; m_pend_y = eng_y; m_pend_err = 0;
                        end else if (cyc - m_launch == TO) begin
                            m_resp = cyc + 1; m_pend_y = '0; m_pend_err = 1;
                        end
                        m_prev = eng_done;
                    end else if (cyc == m_resp) begin
                        m_act = 0;
                        m_ptr = (m_id + 1) % R;
                    end
                end else if (bus.req != '0) begin
                    for (int k = R - 1; k >= 0; k--)
                        if (bus.req[(m_ptr + k) % R]) m_id = (m_ptr + k) % R;
                    m_act = 1; m_launch = cyc + 1; m_resp = -1;
                    m_x = bus.x_in[m_id*W +: W];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
    endtask

    task automatic wait_start(output int t, input int budget);
        t = -1;
        for (int i = 0; i < budget && t < 0; i++) begin
            @(negedge clk);
            if (eng_start === 1'b1) t = cyc;
        end
        if (t < 0) expire("wait_start", budget);
    endtask

    task automatic wait_rsp(output int t, input int budget);
        t = -1;
        for (int i = 0; i < budget && t < 0; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) t = cyc;
        end
        if (t < 0) expire("wait_rsp", budget);
    endtask

    task automatic serve(input int n, input bit drop);
        int t, id;
        for (int i = 0; i < n; i++) begin
            wait_rsp(t, 60);
            if (t < 0) return;
            id = int'(bus.rsp_id);
            got.push_back(id);
            if (drop) begin tick(); bus.req[id] = 1'b0; end
        end
    endtask

    task automatic chk_order(input string nm, input int e[4], input int n, input int base);
        chk({nm, "_count"}, W'(got.size()), W'(base + n));
        for (int i = 0; i < n; i++)
            if (base + i < got.size()) chk(nm, W'(got[base+i]), W'(e[i]));
    endtask

    initial begin
        int L, T;
        int e[4];
        bus.req = '0;
        for (int r = 0; r < R; r++) bus.x_in[r*W +: W] = {32'h1000_0000 + r, 32'h2000_0000 + r};
        repeat (3) tick();
        rst = 1'b0;

        // single request from requester 2
        bus.x_in[2*W +: W] = {32'hc0733333, 32'h40a00000};
        eng_lat = 5;
        eng_y   = {32'h3da0d5a7, 32'h3f7ee6b2};
        tick(); bus.req = 4'b0100;
        wait_start(L, 20);
        chk("s1_gnt_at_launch", bus.gnt, 4'b0100);
        wait_rsp(T, 30);
        chk("s1_rsp_latency", W'(T - L), 64'd6);
        chk("s1_rsp_id", bus.rsp_id, 2'd2);
        chk("s1_rsp_err", bus.rsp_err, 1'b0);
        chk("s1_rsp_y", bus.rsp_y, {32'h3da0d5a7, 32'h3f7ee6b2});
        tick(); bus.req = '0;
        @(negedge clk);
        chk("s1_busy_after_resp", bus.busy, 1'b0);
        repeat (3) tick();

        // all requesters, each dropping after its response; then wrap check
        do_reset();
        eng_lat = 3; eng_y = 64'h1111_2222_3333_4444;
        got.delete();
        tick(); bus.req = 4'b1111;
        serve(4, 1);
        e = '{0, 1, 2, 3}; chk_order("s2_order", e, 4, 0);
        tick(); bus.req = 4'b0011;
        serve(2, 1);
        e = '{0, 1, 0, 0}; chk_order("s2_wrap", e, 2, 4);
        repeat (3) tick();

        // fairness: req[1] permanent, req[3] joins during the first WAIT
        do_reset();
        got.delete();
        tick(); bus.req = 4'b0010;
        wait_start(L, 20);
        tick(); tick(); bus.req[3] = 1'b1;
        serve(4, 0);
        tick(); bus.req = '0;
        e = '{1, 3, 1, 3}; chk_order("s3_fair", e, 4, 0);
        repeat (4) tick();

        // watchdog timeout, then a normal operation
        do_reset();
        eng_lat = -1;
        tick(); bus.req = 4'b0001;
        wait_start(L, 20);
        wait_rsp(T, 40);
        chk("s4_to_latency", W'(T - L), 64'd17);
        chk("s4_to_err", bus.rsp_err, 1'b1);
        chk("s4_to_y", bus.rsp_y, '0);
        chk("s4_to_id", bus.rsp_id, 2'd0);
        tick(); bus.req = '0;
        eng_lat = 4; eng_y = 64'hdead_beef_0bad_f00d;
        tick(); bus.req = 4'b0010;
        wait_rsp(T, 40);
        chk("s4_next_err", bus.rsp_err, 1'b0);
        chk("s4_next_id", bus.rsp_id, 2'd1);
        chk("s4_next_y", bus.rsp_y, 64'hdead_beef_0bad_f00d);
        tick(); bus.req = '0;
        repeat (3) tick();

        // stale done: level high before launch, real rise 3 cycles into WAIT
        do_reset();
        eng_manual = 1'b1; man_done = 1'b1; eng_y = 64'h0123_4567_89ab_cdef;
        tick(); tick(); bus.req = 4'b0001;
        wait_start(L, 20);
        tick();
        tick(); man_done = 1'b0;
        tick(); man_done = 1'b1;
        wait_rsp(T, 30);
        chk("s5_stale_latency", W'(T - L), 64'd4);
        chk("s5_stale_y", bus.rsp_y, 64'h0123_4567_89ab_cdef);
        tick(); bus.req = '0; man_done = 1'b0; eng_manual = 1'b0;
        repeat (3) tick();

        // reset in the middle of WAIT
        do_reset();
        eng_lat = 3; got.delete();
        tick(); bus.req = 4'b0100;
        wait_start(L, 20);
        tick(); rst = 1'b1;
        @(negedge clk);
        chk("s6_rst_engrstn", eng_rst_n, 1'b0);
        chk("s6_rst_gnt", bus.gnt, 4'b0000);
        chk("s6_rst_busy", bus.busy, 1'b0);
        tick(); rst = 1'b0; bus.req = 4'b0101;
        serve(2, 1);
        e = '{0, 2, 0, 0}; chk_order("s6_after_rst", e, 2, 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/sigmoid_arbiter.md
Name: sigmoid_arbiter

Overview:
Shares one N-lane floating-point sigmoid engine (S-bit words, N elements per operation) among R requesters, such as the layer units of the network. Round-robin arbitration picks a requester, latches its operand vector and runs the engine's start/reset/done sequence. It returns the result tagged with the requester id. A watchdog aborts the operation if the engine never signals done.

Parameters:
S, 32, bit width of one float word
N, 2, elements per engine operation
R, 4, number of requesters (at least 2)
TIMEOUT, 64, max cycles in WAIT before abort (at least 2)
IW, $clog2(R), id width (derived)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
req  in  R  per-requester request level; held until that requester's response
x_in  in  R*S*N  operand vectors; slice r = x_in[r*S*N +: S*N]; must be stable while req[r]=1
gnt  out  R  one-hot grant; high from LAUNCH through RESP
rsp_valid  out  1  one-cycle response strobe
rsp_err  out  1  qualifies rsp_valid; 1 = timeout abort
rsp_id  out  IW  requester being answered
rsp_y  out  S*N  result vector (0 on error)
busy  out  1  state != IDLE
eng_rst_n  out  1  engine clear, active-low
eng_start  out  1  engine start
eng_x  out  S*N  engine operand
eng_y  in  S*N  engine result
eng_done  in  1  engine completion level

Behaviour:
- Reset: applies while rst=1 and wins over everything else, including mid-operation.
  - State goes to IDLE and the round-robin pointer to 0.
  - gnt=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_y=0, busy=0.
  - eng_start=0, eng_x=0, eng_rst_n=0 (engine held cleared).
  - The watchdog counter and the done_q register are cleared.
  - Any in-flight operation is dropped; no response is issued for it.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - eng_rst_n=1.
  - If req != 0, choose the first set bit at or after the pointer, searching cyclically.
  - On that edge: set gnt one-hot, latch the chosen x_in slice into eng_x, latch the id, go to LAUNCH.
- LAUNCH: exactly one cycle, eng_rst_n=0 and eng_start=1, which clears the engine while presenting start.
  - Next state is WAIT.
  - Clear the watchdog counter.
  - Set done_q=1 so a done level left over from before is ignored.
- WAIT:
  - eng_rst_n=1, eng_start=0.
  - done_q tracks eng_done every cycle; completion is the rising edge eng_done=1 && done_q=0.
  - On completion: capture eng_y into rsp_y, set rsp_err=0, go to RESP.
  - Otherwise, if the counter equals TIMEOUT-1: set rsp_y=0, rsp_err=1, go to RESP.
  - Otherwise increment the counter (width $clog2(TIMEOUT+1), no wrap).
  - If completion and timeout fall in the same cycle, completion wins.
- RESP: one cycle.
  - rsp_valid=1, rsp_id = latched id, gnt unchanged.
  - Pointer becomes (id+1) mod R, wrapping from R-1 to 0.
  - Next state is IDLE with gnt=0.
  - rsp_y, rsp_err and rsp_id hold their values until the next RESP.
- Fairness: a requester that keeps req high after its response is served again only after every other active requester has been served.
- Changing req[r] or the x_in slice after grant has no effect; the operand is latched.
- Dropping req of the granted requester mid-operation does not abort; the response is still issued.
- Minimum throughput: one operation per 4+L cycles, where L is the engine latency in WAIT cycles to done.
- eng_x stays stable from LAUNCH through RESP.

Test Plan:
- Single request: req=4'b0100, slice 2 = {32'hc0733333,32'h40a00000}, engine model asserts done 5 cycles after LAUNCH with y={32'h3da0d5a7,32'h3f7ee6b2} -> gnt=4'b0100 from LAUNCH; eng_rst_n=0/eng_start=1 for exactly 1 cycle; rsp_valid pulse with rsp_id=2, rsp_err=0 and that y; busy drops the cycle after RESP.
- All requesters: req=4'b1111 held, each dropped after its own response -> service order 0,1,2,3; then req=4'b0011 -> order 0,1, confirming pointer wrap.
- Fairness: req[1] held high permanently, req[3] raised during requester 1's WAIT -> order 1,3,1,3.
- Timeout: TIMEOUT=16, engine never asserts done -> rsp_valid with rsp_err=1, rsp_y=0 on the 17th cycle after LAUNCH; the next request is served normally.
- Stale done: eng_done stuck at 1 before LAUNCH, then falls and rises 3 cycles into WAIT -> completion only on that rise, not in the first WAIT cycle.
- Reset mid-operation: assert rst for 1 cycle in WAIT -> all outputs at reset values, no rsp_valid, eng_rst_n=0 during rst; the subsequent request from requester 0 is granted first.
